// File: rtl/processing_grid_pkg.sv
// processing_grid_pkg: sample/coefficient types and the 13-point stencil geometry.
package processing_grid_pkg;
    localparam int c_datawidth = 32;
    localparam int c_coefficientCount = 13;
    localparam int c_grid_width = 12;
    localparam int c_grid_height = 12;

    typedef logic signed [c_datawidth-1:0] t_sample;
    typedef t_sample t_coefficients [0:c_coefficientCount-1];

    localparam int c_dx [0:c_coefficientCount-1] = '{0, -1, 0, 1, -2, -1, 0, 1, 2, -1, 0, 1, 0};
    localparam int c_dy [0:c_coefficientCount-1] = '{-2, -1, -1, -1, 0, 0, 0, 0, 0, 1, 1, 1, 2};

    function automatic logic on_grid(int x, int y, int w, int h);
        return x >= 0 && x < w && y >= 0 && y < h;
    endfunction
endpackage

// File: rtl/processing_grid_pe.sv
// processing_grid_pe: combinational stencil evaluation for one grid point.
module processing_grid_pe
    import processing_grid_pkg::*;
(
    input  t_sample       neighbours [0:c_coefficientCount-1],
    input  t_sample       centre_prev,
    input  t_coefficients coefficients_n,
    input  t_coefficients coefficients_n_minus1,
    output t_sample       result
);
    logic signed [67:0] acc;

    // Full-width products summed wide, then floor-shifted and wrapped to 32 bits.
    always_comb begin
        acc = 68'(64'(coefficients_n_minus1[6]) * 64'(centre_prev));
        for (int k = 0; k < c_coefficientCount; k++)
            acc = acc + 68'(64'(coefficients_n[k]) * 64'(neighbours[k]));
        result = t_sample'(acc >>> 16);
    end
endmodule

// File: rtl/processing_grid.sv
// processing_grid: raster-swept finite-difference wave solver, one point per cycle,
// one pickup sample per 144-cycle sweep.
module processing_grid
    import processing_grid_pkg::*;
#(
    parameter int c_gridWidth  = c_grid_width,
    parameter int c_gridHeight = c_grid_height,
    parameter int c_exciteX    = 5,
    parameter int c_exciteY    = 5,
    parameter int c_pickupX    = 5,
    parameter int c_pickupY    = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  t_coefficients i_coefficientsN,
    input  t_coefficients i_coefficientsNMinus1,
    output logic          o_outputReady,
    output t_sample       o_output
);
    localparam int c_points = c_gridWidth * c_gridHeight;
    localparam int c_aw = $clog2(c_points);
    localparam int c_xw = $clog2(c_gridWidth);
    localparam int c_yw = $clog2(c_gridHeight);
    localparam int c_excite = c_exciteY * c_gridWidth + c_exciteX;
    localparam int c_pickup = c_pickupY * c_gridWidth + c_pickupX;

    t_sample bank [0:1][0:c_points-1];
    t_sample hood [0:c_coefficientCount-1];
    t_sample prev, next_val, hold;
    logic sel, last;
    logic [c_xw-1:0] x;
    logic [c_yw-1:0] y;
    logic [c_aw-1:0] idx;

    // Off-grid neighbours read as zero; bank[sel] holds u^n.
    always_comb begin
        idx = c_aw'(int'(y) * c_gridWidth + int'(x));
        last = x == c_xw'(c_gridWidth - 1) && y == c_yw'(c_gridHeight - 1);
        prev = bank[~sel][idx];
        for (int k = 0; k < c_coefficientCount; k++)
            hood[k] = on_grid(int'(x) + c_dx[k], int'(y) + c_dy[k], c_gridWidth, c_gridHeight)
                ? bank[sel][c_aw'((int'(y) + c_dy[k]) * c_gridWidth + int'(x) + c_dx[k])] : '0;
    end

    processing_grid_pe pe (
        .neighbours           (hood),
        .centre_prev          (prev),
        .coefficients_n       (i_coefficientsN),
        .coefficients_n_minus1(i_coefficientsNMinus1),
        .result               (next_val)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int p = 0; p < c_points; p++) begin
                bank[0][p] <= (p == c_excite) ? 32'h0001_0000 : '0;
                bank[1][p] <= '0;
            end
            x <= '0;
            y <= '0;
            sel <= 1'b0;
            hold <= '0;
            o_output <= '0;
            o_outputReady <= 1'b0;
        end else begin
            bank[~sel][idx] <= next_val;
            if (idx == c_aw'(c_pickup))
                hold <= next_val;
            o_outputReady <= last;
            if (last) begin
                sel <= ~sel;
                o_output <= (idx == c_aw'(c_pickup)) ? next_val : hold;
                x <= '0;
                y <= '0;
            end else if (x == c_xw'(c_gridWidth - 1)) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_processing_grid.sv
// tb_processing_grid: table-driven sweeps with a reference grid model feeding a
// scoreboard of expected pickup samples, plus a mid-sweep reset sequence.
module tb_processing_grid;
    import processing_grid_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    t_coefficients cn, cm;
    logic ready;
    t_sample out;

    always #5 clk = ~clk;

    processing_grid dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_coefficientsN      (cn),
        .i_coefficientsNMinus1(cm),
        .o_outputReady        (ready),
        .o_output             (out)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    t_sample exp_q [$];
    t_sample last_exp = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    endtask

    // Reference model: separate next-state array, independent stencil tables.
    int mdx [13] = '{0, -1, 0, 1, -2, -1, 0, 1, 2, -1, 0, 1, 0};
    int mdy [13] = '{-2, -1, -1, -1, 0, 0, 0, 0, 0, 1, 1, 1, 2};
    t_sample m_cur [144];
    t_sample m_prev [144];

    task automatic model_reset();
        for (int p = 0; p < 144; p++) begin
            m_cur[p] = (p == 65) ? 32'h0001_0000 : 32'h0;
            m_prev[p] = '0;
        end
    endtask

    function automatic t_sample model_point(int px, int py);
        logic signed [71:0] s;
        s = 72'(cm[6]) * 72'(m_prev[py * 12 + px]);
        for (int k = 0; k < 13; k++) begin
            int nx = px + mdx[k];
            int ny = py + mdy[k];
            if (nx >= 0 && nx < 12 && ny >= 0 && ny < 12)
                s = s + 72'(cn[k]) * 72'(m_cur[ny * 12 + nx]);
        end
        return s[47:16];
    endfunction

    task automatic model_sweep(output t_sample pick);
        t_sample nxt [144];
        for (int py = 0; py < 12; py++)
            for (int px = 0; px < 12; px++)
                nxt[py * 12 + px] = model_point(px, py);
        m_prev = m_cur;
        m_cur = nxt;
        pick = nxt[65];
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ready", 32'(ready), 32'h0);
            chk("reset_output", out, 32'h0);
        end else if (ready) begin
            chk("strobe_phase", 32'(cyc % 144), 32'h0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
            end else begin
                last_exp = exp_q.pop_front();
                chk("sample", out, last_exp);
            end
        end
    end

    task automatic set_coeffs(logic [31:0] cx, logic [31:0] c6, logic [31:0] cm6, logic rnd);
        for (int k = 0; k < 13; k++) begin
            cn[k] = rnd ? t_sample'($urandom) : ((k == 2 || k == 5 || k == 7 || k == 10) ? cx : 32'h0);
            cm[k] = rnd ? t_sample'($urandom) : 32'h0;
        end
        cn[6] = rnd ? t_sample'($urandom_range(0, 32'h0002_0000)) : c6;
        cm[6] = rnd ? t_sample'($urandom) : cm6;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'h0);
    endtask

    typedef struct {
        logic [31:0] cx;
        logic [31:0] c6;
        logic [31:0] cm6;
        logic        rnd;
        logic        use_tab;
        int          sweeps;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [4];

    initial begin
        t_sample pick;
        vecs[0] = '{32'h0000_7ee3, 32'h0000_045f, 32'hffff_0015, 1'b0, 1'b1, 3, 32'h0000_045f, 32'hffff_fbb9};
        vecs[1] = '{32'h0, 32'h0001_0000, 32'h0, 1'b0, 1'b1, 3, 32'h0001_0000, 32'h0001_0000};
        vecs[2] = '{32'h0, 32'h0, 32'h0001_0000, 1'b0, 1'b1, 4, 32'h0, 32'h0001_0000};
        vecs[3] = '{32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'h0};
        set_coeffs(32'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            set_coeffs(vecs[i].cx, vecs[i].c6, vecs[i].cm6, vecs[i].rnd);
            exp_q.delete();
            model_reset();
            for (int s = 0; s < vecs[i].sweeps; s++) begin
                model_sweep(pick);
                exp_q.push_back((vecs[i].use_tab && s < 2) ? (s == 0 ? vecs[i].exp0 : vecs[i].exp1) : pick);
            end
            do_reset();
            drain(vecs[i].sweeps * 144 + 20);
            repeat (30) @(negedge clk);
            chk("hold_between_strobes", out, last_exp);
        end

        // Reset 70 cycles into a sweep must abort it and restart the 144-cycle schedule.
        set_coeffs(32'h0000_7ee3, 32'h0000_045f, 32'hffff_0015, 1'b0);
        exp_q.delete();
        do_reset();
        repeat (70) @(posedge clk);
        do_reset();
        exp_q.push_back(32'h0000_045f);
        drain(144 + 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
